// File: rtl/shift_result_buffer_if.sv
// Handshake bundle between the barrel shifter (producer), the result buffer
// and the downstream consumer.
interface shift_result_buffer_if #(
  parameter int WIDTH = 32
);
  // valid/ready: a transfer happens on a rising edge where both are high;
  // valid and payload stay stable until accepted, and ready never waits on valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic [1:0]       in_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [1:0]       out_ctrl;
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, in_y, in_ctrl, out_ready,
    input  in_ready, out_valid, out_y, out_ctrl, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_y, in_ctrl, out_ready,
    output in_ready, out_valid, out_y, out_ctrl, out_zero, out_neg
  );
endinterface

// File: rtl/shift_result_buffer.sv
// Circular FIFO for barrel shifter results; zero/neg flags are captured at
// enqueue so the consumer never sees a compare path behind out_y.
module shift_result_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  shift_result_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                xfer_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_y    [DEPTH];
  logic [1:0]       mem_ctrl [DEPTH];
  logic             mem_zero [DEPTH];
  logic             mem_neg  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   xfer_q, xfer_d;
  logic          push, pop, not_empty;

  assign not_empty    = (count_q != '0);
  assign bus.in_ready = (count_q < FULL);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = not_empty && bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    xfer_d   = xfer_q;
    if (flush) begin
      // Flush drops in-flight transfers but keeps the transfer tally.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        xfer_d   = xfer_q + 16'd1;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      xfer_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      xfer_q   <= xfer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_y[wr_ptr_q]    <= bus.in_y;
      mem_ctrl[wr_ptr_q] <= bus.in_ctrl;
      mem_zero[wr_ptr_q] <= (bus.in_y == '0);
      mem_neg[wr_ptr_q]  <= bus.in_y[WIDTH-1];
    end
  end

  // Payload is gated by occupancy so an empty or reset buffer reads as zero.
  assign bus.out_valid = not_empty;
  assign bus.out_y     = not_empty ? mem_y[rd_ptr_q]    : '0;
  assign bus.out_ctrl  = not_empty ? mem_ctrl[rd_ptr_q] : 2'd0;
  assign bus.out_zero  = not_empty && mem_zero[rd_ptr_q];
  assign bus.out_neg   = not_empty && mem_neg[rd_ptr_q];

  assign count    = count_q;
  assign xfer_cnt = xfer_q;
endmodule
